camera_screen_projector: RTL and testbench
==========================================

CAMERA_SCREEN_PROJECTOR -- requirements
Module: camera_screen_projector

Interface
REQ-001 SHALL have parameter NEAR_Z, default 32'h0000_1000 (1/16, q16_16_t), near-plane depth; legal range 32'h0000_0100..32'h7FFF_FFFF.
REQ-002 SHALL have clk  input  1  single clock; all logic is on the rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have focal_length  input  q16_16_t  focal length accompanying the triangle from the world-to-camera stage.
REQ-005 SHALL have triangle  input  triangle_t  camera-space triangle (v0..v2: pos, color).
REQ-006 SHALL have in_valid  input  1  and in_ready  output  1  as the upstream handshake.
REQ-007 SHALL have out_triangle  output  triangle_t  screen-space triangle; out_valid  output  1; out_ready  input  1.
REQ-008 SHALL have busy  output  1  high when state != IDLE or out_valid is high.
REQ-009 SHALL have culled  output  1  one-cycle pulse per dropped triangle (tied 0 when PROJ_NEAR_CULL_EN is undefined).

Function
REQ-010 SHALL implement FSM IDLE -> CHECK -> {DIV -> MUL_K -> MUL_XY} x3 -> OUT -> IDLE.
REQ-011 in_ready SHALL equal (state==IDLE && !out_valid); no overlap of triangles.
REQ-012 On the in_valid && in_ready edge SHALL latch triangle and focal_length and enter CHECK.
REQ-013 CHECK (1 cycle) SHALL form z_eff per vertex and make the cull decision (see Configuration).
REQ-014 DIV SHALL compute inv_z = floor(2^32 / z_eff) with an unsigned restoring divider, 1 quotient bit per cycle, exactly 32 cycles; result is Q16.16.
REQ-015 MUL_K (1 cycle) SHALL compute k = mul_q(focal, inv_z); mul_q = 64-bit signed product, arithmetic shift right 16, truncate to 32 bits.
REQ-016 MUL_XY (1 cycle) SHALL write out_triangle.vi: pos.x = mul_q(k, x), pos.y = mul_q(k, y), pos.z = inv_z, color unchanged.
REQ-017 Vertices SHALL be processed in order v0, v1, v2; 34 cycles per vertex.
REQ-018 out_valid SHALL rise exactly 103 edges after the accepting edge (1 + 3x34) for a non-culled triangle.
REQ-019 out_valid SHALL be sticky; out_triangle SHALL be stable while out_valid && !out_ready.
REQ-020 On the out_valid && out_ready edge SHALL clear out_valid and return to IDLE; in_ready is high the following cycle.
REQ-021 out_triangle bits not yet written for the current triangle SHALL hold their previous value; only REQ-016 writes modify them.

Reset
REQ-022 While rst is low at an edge: state=IDLE, out_valid=0, culled=0, out_triangle=0, divider/counters=0.
REQ-023 in_ready SHALL be 0 while rst is low and 1 in the first cycle after release.
REQ-024 Reset asserted in any state (including mid-DIV or OUT) SHALL discard the in-flight triangle with no output.

Configuration
REQ-025 Macro PROJ_NEAR_CULL_EN defined: if any vertex has signed z < NEAR_Z, CHECK SHALL return to IDLE, pulse culled for 1 cycle, emit nothing; otherwise z_eff = z.
REQ-026 Macro undefined: z_eff = max(z, NEAR_Z) (signed compare), every accepted triangle is emitted, culled tied 0.

Verification
REQ-027 f=0x0001_0000, all v=(0x0002_0000, 0x0004_0000, 0x0002_0000) -> after 103 cycles each vertex pos=(0x0001_0000, 0x0002_0000, 0x0000_8000), color intact.
REQ-028 Cull build, v1.z=0 -> culled pulse 1 cycle after accept, out_valid never rises, in_ready high 2 cycles after accept.
REQ-029 Non-cull build, f=1.0, v=(1.0, 0, 0) -> inv_z=0x0010_0000, pos.x=0x0010_0000.
REQ-030 out_ready low 10 cycles after out_valid -> out_triangle stable, in_ready=0, busy=1; handshake then IDLE.
REQ-031 rst low at cycle 40 (mid-DIV) -> out_valid stays 0; next triangle yields correct result 103 cycles after accept.
REQ-032 Two back-to-back triangles, out_ready=1 -> second accepted the cycle after the first output handshake; both outputs correct.

Source files
------------

// File: rtl/camera_screen_projector.sv
// rtl/camera_screen_projector.sv - camera-space to screen-space triangle projection, one vertex at a time.
// Optional near-plane culling is enabled by defining PROJ_NEAR_CULL_EN.
package camera_screen_projector_pkg;
   typedef logic [31:0] q16_16_t;
   typedef struct packed { q16_16_t x; q16_16_t y; q16_16_t z; } pos_t;
   typedef struct packed { pos_t pos; logic [23:0] color; } vertex_t;
   typedef struct packed { vertex_t v0; vertex_t v1; vertex_t v2; } triangle_t;
endpackage

module camera_screen_projector
   import camera_screen_projector_pkg::*;
#(
   parameter q16_16_t NEAR_Z = 32'h0000_1000
) (
   input  logic      clk,
   input  logic      rst,
   input  q16_16_t   focal_length,
   input  triangle_t triangle,
   input  logic      in_valid,
   output logic      in_ready,
   output triangle_t out_triangle,
   output logic      out_valid,
   input  logic      out_ready,
   output logic      busy,
   output logic      culled
);

   typedef enum logic [2:0] {IDLE, CHECK, DIV, MUL_K, MUL_XY, OUT} state_t;

   state_t    state, next_state;
   triangle_t tri_q;
   q16_16_t   focal_q, k;
   q16_16_t   zeff0, zeff1, zeff2;
   logic [31:0] rem, quo;
   logic [4:0]  cnt;
   logic [1:0]  vidx;

   vertex_t     cur, new_v;
   q16_16_t     z_cur;
   logic [32:0] sh;
   logic [31:0] diff, rem_next;
   logic        ge, near_fail;

   // Q16.16 multiply: full signed product, arithmetic shift, keep low 32 bits.
   function automatic q16_16_t mul_q(input q16_16_t a, input q16_16_t b);
      logic signed [63:0] p;
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return q16_16_t'(p >>> 16);
   endfunction

`ifdef PROJ_NEAR_CULL_EN
   function automatic q16_16_t form_z(input q16_16_t z);
      return z;
   endfunction
   assign near_fail = ($signed(tri_q.v0.pos.z) < $signed(NEAR_Z)) ||
                      ($signed(tri_q.v1.pos.z) < $signed(NEAR_Z)) ||
                      ($signed(tri_q.v2.pos.z) < $signed(NEAR_Z));
`else
   function automatic q16_16_t form_z(input q16_16_t z);
      return ($signed(z) < $signed(NEAR_Z)) ? NEAR_Z : z;
   endfunction
   assign near_fail = 1'b0;
`endif

   always_comb begin
      cur   = tri_q.v0;
      z_cur = zeff0;
      case (vidx)
         2'd1:    begin cur = tri_q.v1; z_cur = zeff1; end
         2'd2:    begin cur = tri_q.v2; z_cur = zeff2; end
         default: begin cur = tri_q.v0; z_cur = zeff0; end
      endcase
      // Dividend bits below 2^32 are all zero, so each step shifts in a 0.
      sh       = {rem, 1'b0};
      ge       = sh >= {1'b0, z_cur};
      diff     = sh[31:0] - z_cur;
      rem_next = ge ? diff : sh[31:0];
      new_v.pos.x = mul_q(k, cur.pos.x);
      new_v.pos.y = mul_q(k, cur.pos.y);
      new_v.pos.z = quo;
      new_v.color = cur.color;
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      culled     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = rst && !out_valid;
            if (in_valid && in_ready) next_state = CHECK;
         end
         CHECK: begin
            if (near_fail) begin
               next_state = IDLE;
               culled     = 1'b1;
            end else begin
               next_state = DIV;
            end
         end
         DIV:     if (cnt == 5'd31) next_state = MUL_K;
         MUL_K:   next_state = MUL_XY;
         MUL_XY:  next_state = (vidx == 2'd2) ? OUT : DIV;
         OUT:     if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
      busy = (state != IDLE) || out_valid;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tri_q        <= '0;
         focal_q      <= '0;
         k            <= '0;
         zeff0        <= '0;
         zeff1        <= '0;
         zeff2        <= '0;
         rem          <= '0;
         quo          <= '0;
         cnt          <= '0;
         vidx         <= '0;
         out_valid    <= 1'b0;
         out_triangle <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid && in_ready) begin
               tri_q   <= triangle;
               focal_q <= focal_length;
            end
            CHECK: begin
               zeff0 <= form_z(tri_q.v0.pos.z);
               zeff1 <= form_z(tri_q.v1.pos.z);
               zeff2 <= form_z(tri_q.v2.pos.z);
               rem   <= 32'd1;
               quo   <= '0;
               cnt   <= '0;
               vidx  <= '0;
            end
            DIV: begin
               rem <= rem_next;
               quo <= {quo[30:0], ge};
               cnt <= cnt + 5'd1;
            end
            MUL_K: k <= mul_q(focal_q, quo);
            MUL_XY: begin
               case (vidx)
                  2'd0:    out_triangle.v0 <= new_v;
                  2'd1:    out_triangle.v1 <= new_v;
                  default: out_triangle.v2 <= new_v;
               endcase
               rem  <= 32'd1;
               quo  <= '0;
               cnt  <= '0;
               vidx <= vidx + 2'd1;
               if (vidx == 2'd2) out_valid <= 1'b1;
            end
            OUT: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_camera_screen_projector.sv
// tb/tb_camera_screen_projector.sv - scoreboard bench for camera_screen_projector.
module tb_camera_screen_projector;
   import camera_screen_projector_pkg::*;

   localparam q16_16_t NEAR = 32'h0000_1000;

   logic      clk = 1'b0;
   logic      rst = 1'b0;
   q16_16_t   focal_length = '0;
   triangle_t triangle = '0;
   logic      in_valid = 1'b0;
   logic      in_ready;
   triangle_t out_triangle;
   logic      out_valid;
   logic      out_ready = 1'b1;
   logic      busy;
   logic      culled;

   int n_pass = 0;
   int n_tot  = 0;
   int cyc    = 0;
   int acc_cyc, hs_cyc;
   triangle_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   camera_screen_projector dut (
      .clk(clk), .rst(rst), .focal_length(focal_length), .triangle(triangle),
      .in_valid(in_valid), .in_ready(in_ready), .out_triangle(out_triangle),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .culled(culled)
   );

   function automatic q16_16_t mq(input q16_16_t a, input q16_16_t b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return q16_16_t'(p >>> 16);
   endfunction

   function automatic q16_16_t inv_model(input q16_16_t z);
      longint zz, q;
      zz = ($signed(z) < $signed(NEAR)) ? longint'(NEAR) : longint'(z);
      q  = 64'h1_0000_0000 / zz;
      return q16_16_t'(q);
   endfunction

   function automatic vertex_t proj_model(input vertex_t v, input q16_16_t f);
      vertex_t r;
      q16_16_t iz, kk;
      iz = inv_model(v.pos.z);
      kk = mq(f, iz);
      r.pos.x = mq(kk, v.pos.x);
      r.pos.y = mq(kk, v.pos.y);
      r.pos.z = iz;
      r.color = v.color;
      return r;
   endfunction

   function automatic triangle_t tri_model(input triangle_t t, input q16_16_t f);
      triangle_t r;
      r.v0 = proj_model(t.v0, f);
      r.v1 = proj_model(t.v1, f);
      r.v2 = proj_model(t.v2, f);
      return r;
   endfunction

   function automatic vertex_t mkv(input q16_16_t x, input q16_16_t y, input q16_16_t z,
                                   input logic [23:0] c);
      vertex_t v;
      v.pos.x = x; v.pos.y = y; v.pos.z = z; v.color = c;
      return v;
   endfunction

   function automatic vertex_t rv();
      return mkv($urandom, $urandom, $urandom_range(32'h0080_0000, 32'h0000_1000),
                 24'($urandom));
   endfunction

   task automatic send(input triangle_t t, input q16_16_t f, input bit push);
      int n = 0;
      @(negedge clk);
      triangle = t; focal_length = f; in_valid = 1'b1;
      while (!in_ready && n < 400) begin @(negedge clk); n++; end
      n_tot++;
      if (!in_ready) begin
         $display("FAIL send_timeout in_ready=%b required 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      n_pass++;
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      if (push) exp_q.push_back(tri_model(t, f));
   endtask

   task automatic recv(input int hold, input string name);
      int n = 0;
      triangle_t e, snap;
      if (hold > 0) out_ready = 1'b0;
      while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
      n_tot++;
      if (n != 103) $display("FAIL %s_latency got %0d required 103", name, n);
      else n_pass++;
      if (!out_valid) begin out_ready = 1'b1; return; end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      n_tot++;
      if (out_triangle !== e)
         $display("FAIL %s_data got %h required %h", name, out_triangle, e);
      else n_pass++;
      snap = out_triangle;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         n_tot++;
         if (out_triangle !== snap || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1)
            $display("FAIL %s_hold cyc%0d stable=%b in_ready=%b busy=%b out_valid=%b required 1 0 1 1",
                     name, i, out_triangle === snap, in_ready, busy, out_valid);
         else n_pass++;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      hs_cyc = cyc;
      n_tot++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL %s_handshake out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tot++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || culled !== 1'b0)
         $display("FAIL reset_ctrl in_ready=%b out_valid=%b busy=%b culled=%b required 0 0 0 0",
                  in_ready, out_valid, busy, culled);
      else n_pass++;
      n_tot++;
      if (out_triangle !== '0) $display("FAIL reset_data got %h required 0", out_triangle);
      else n_pass++;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      n_tot++;
      if (in_ready !== 1'b1) $display("FAIL reset_release in_ready=%b required 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_basic();
      triangle_t t;
      t.v0 = mkv(32'h0002_0000, 32'h0004_0000, 32'h0002_0000, 24'h112233);
      t.v1 = mkv(32'h0002_0000, 32'h0004_0000, 32'h0002_0000, 24'h445566);
      t.v2 = mkv(32'h0002_0000, 32'h0004_0000, 32'h0002_0000, 24'h778899);
      send(t, 32'h0001_0000, 1'b1);
      recv(0, "basic");
      n_tot++;
      if (out_triangle.v1 !== mkv(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 24'h445566))
         $display("FAIL basic_const got %h required %h", out_triangle.v1,
                  mkv(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 24'h445566));
      else n_pass++;
   endtask

`ifndef PROJ_NEAR_CULL_EN
   task automatic test_clamp();
      triangle_t t;
      t.v0 = mkv(32'h0001_0000, 32'h0, 32'h0, 24'hABCDEF);
      t.v1 = mkv(32'h0001_0000, 32'h0, 32'hFFFF_0000, 24'h000001);
      t.v2 = mkv(32'h0001_0000, 32'h0, 32'h0000_0FFF, 24'h000002);
      send(t, 32'h0001_0000, 1'b1);
      recv(0, "clamp");
      n_tot++;
      if (out_triangle.v0.pos.x !== 32'h0010_0000 || out_triangle.v0.pos.z !== 32'h0010_0000)
         $display("FAIL clamp_const x=%h z=%h required 00100000 00100000",
                  out_triangle.v0.pos.x, out_triangle.v0.pos.z);
      else n_pass++;
   endtask
`else
   task automatic test_cull();
      triangle_t t;
      bit seen = 1'b0;
      t.v0 = mkv(32'h0001_0000, 32'h0, 32'h0002_0000, 24'h1);
      t.v1 = mkv(32'h0001_0000, 32'h0, 32'h0, 24'h2);
      t.v2 = mkv(32'h0001_0000, 32'h0, 32'h0002_0000, 24'h3);
      send(t, 32'h0001_0000, 1'b0);
      n_tot++;
      if (culled !== 1'b1) $display("FAIL cull_pulse culled=%b required 1", culled);
      else n_pass++;
      @(posedge clk); #1;
      n_tot++;
      if (culled !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL cull_after culled=%b in_ready=%b required 0 1", culled, in_ready);
      else n_pass++;
      repeat (120) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      n_tot++;
      if (seen) $display("FAIL cull_no_output out_valid seen=1 required 0");
      else n_pass++;
   endtask
`endif

   task automatic test_backpressure();
      triangle_t t;
      t.v0 = rv(); t.v1 = rv(); t.v2 = rv();
      send(t, 32'h0002_8000, 1'b1);
      recv(10, "backpressure");
   endtask

   task automatic test_reset_mid();
      triangle_t t;
      bit seen = 1'b0;
      t.v0 = rv(); t.v1 = rv(); t.v2 = rv();
      send(t, 32'h0001_0000, 1'b1);
      repeat (39) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      exp_q.delete();
      repeat (150) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      n_tot++;
      if (seen) $display("FAIL reset_mid_no_output out_valid seen=1 required 0");
      else n_pass++;
      t.v0 = rv(); t.v1 = rv(); t.v2 = rv();
      send(t, 32'hFFFF_0000, 1'b1);
      recv(0, "after_reset");
   endtask

   task automatic test_back_to_back();
      triangle_t t1, t2;
      t1.v0 = rv(); t1.v1 = rv(); t1.v2 = rv();
      t2.v0 = rv(); t2.v1 = rv(); t2.v2 = rv();
      send(t1, 32'h0000_C000, 1'b1);
      recv(0, "b2b_first");
      send(t2, 32'h0003_0000, 1'b1);
      n_tot++;
      if (acc_cyc != hs_cyc + 1)
         $display("FAIL b2b_accept_cycle got %0d required %0d", acc_cyc, hs_cyc + 1);
      else n_pass++;
      recv(0, "b2b_second");
   endtask

   task automatic test_random();
      triangle_t t;
      for (int i = 0; i < 4; i++) begin
         t.v0 = rv(); t.v1 = rv(); t.v2 = rv();
         send(t, $urandom_range(32'h0004_0000, 32'h0000_4000), 1'b1);
         recv(0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
`ifndef PROJ_NEAR_CULL_EN
      test_clamp();
`else
      test_cull();
`endif
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
